// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, state type and size helpers for the load/store aligner
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_ok(input logic we, input logic [2:0] funct3);
    if (we) funct3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    funct3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// rtl/lsu_load_format.sv - shifts the {hi,lo} word pair down by the byte offset and extends per funct3
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [63:0] shifted;

  always_comb begin
    shifted = data >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'b0, shifted[7:0]};
      F3_HU:   result = {16'b0, shifted[15:0]};
      default: result = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - splits loads/stores into one or two word-aligned byte-enabled memory accesses
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [1:0]            offset;
  logic [2:0]            size;
  logic [3:0]            size_mask;
  logic [7:0]            be_full;
  logic [2*DATA_W-1:0]   wdata_full;
  logic                  crosses;
  logic [DM_ADDRESS-3:0] word_idx, next_word_idx;
  logic [2*DATA_W-1:0]   fmt_data;
  logic [DATA_W-1:0]     fmt_result;

  always_comb begin
    offset        = addr_q[1:0];
    size          = size_of(funct3_q);
    size_mask     = (size == 3'd1) ? 4'b0001 : (size == 3'd2) ? 4'b0011 : 4'b1111;
    be_full       = {4'b0000, size_mask} << offset;
    wdata_full    = {{DATA_W{1'b0}}, wdata_q} << {offset, 3'b000};
    crosses       = ({2'b00, offset} + {1'b0, size}) > 4'd4;
    word_idx      = addr_q[DM_ADDRESS-1:2];
    // Wraps modulo the word count, so the last word is followed by word 0.
    next_word_idx = word_idx + 1'b1;
    fmt_data      = (state_q == ACC1) ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
  end

  lsu_load_format u_fmt (
    .data   (fmt_data),
    .offset (offset),
    .funct3 (funct3_q),
    .result (fmt_result)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready    = 1'b0;
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    mem_wdata    = '0;
    resp_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d         = req_we;
          funct3_d     = req_funct3;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = !funct3_ok(req_we, req_funct3);
          state_d      = funct3_ok(req_we, req_funct3) ? ACC0 : RESP;
        end
      end
      ACC0: begin
        mem_addr  = {word_idx, 2'b00};
        mem_be    = be_full[3:0];
        mem_wdata = wdata_full[DATA_W-1:0];
        mem_re    = !we_q;
        mem_we    = we_q;
        if (!we_q) lo_d = mem_rdata;
        if (crosses) begin
          state_d = ACC1;
        end else begin
          state_d = RESP;
          if (!we_q) resp_rdata_d = fmt_result;
        end
      end
      ACC1: begin
        mem_addr  = {next_word_idx, 2'b00};
        mem_be    = be_full[7:4];
        mem_wdata = wdata_full[2*DATA_W-1:DATA_W];
        mem_re    = !we_q;
        mem_we    = we_q;
        state_d   = RESP;
        if (!we_q) resp_rdata_d = fmt_result;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - directed bench for lsu_align with a byte-enabled word memory model
module tb_lsu_align;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_run;
  int n_fail;

  logic [31:0] mem [128];

  lsu_align #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Presents one request for exactly one accepting edge; returns #1 after that edge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_run++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_run++; if ({mem_re, mem_we, mem_be} !== 6'b0) begin n_fail++; $display("FAIL rst_mem_ctl got %b want 000000", {mem_re, mem_we, mem_be}); end
    n_run++; if ({mem_addr, mem_wdata} !== 41'b0) begin n_fail++; $display("FAIL rst_mem_addr_data got %h/%h want 0/0", mem_addr, mem_wdata); end
    n_run++; if ({resp_valid, resp_err, resp_rdata} !== 34'b0) begin n_fail++; $display("FAIL rst_resp got %b/%b/%h want 0/0/0", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_word;
    send(1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    @(negedge clk);
    n_run++; if ({mem_we, mem_re, mem_be} !== 6'b101111) begin n_fail++; $display("FAIL sw_ctl got we=%b re=%b be=%b want 1/0/1111", mem_we, mem_re, mem_be); end
    n_run++; if (mem_addr !== 9'h010 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_addr_data got %h/%h want 010/deadbeef", mem_addr, mem_wdata); end
    n_run++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_busy_ready got %b want 0", req_ready); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL sw_resp got %b/%h/%b want 1/0/0", resp_valid, resp_rdata, resp_err); end
    send(1'b0, 3'b010, 9'h010, 32'h0);
    @(negedge clk);
    n_run++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_acc got re=%b we=%b rv=%b want 1/0/0", mem_re, mem_we, resp_valid); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_resp got %b/%h want 1/deadbeef", resp_valid, resp_rdata); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_hold got %b/%b/%h want 0/1/deadbeef", resp_valid, req_ready, resp_rdata); end
  endtask

  task automatic test_byte;
    send(1'b1, 3'b000, 9'h013, 32'h000000F0);
    @(negedge clk);
    n_run++; if (mem_be !== 4'b1000 || mem_wdata !== 32'hF0000000) begin n_fail++; $display("FAIL sb_lane got be=%b data=%h want 1000/f0000000", mem_be, mem_wdata); end
    @(negedge clk);
    send(1'b0, 3'b000, 9'h013, 32'h0);
    @(negedge clk); @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_sext got %b/%h want 1/fffffff0", resp_valid, resp_rdata); end
    send(1'b0, 3'b100, 9'h013, 32'h0);
    @(negedge clk); @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000F0) begin n_fail++; $display("FAIL lbu_zext got %b/%h want 1/000000f0", resp_valid, resp_rdata); end
  endtask

  task automatic test_hold;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h010; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_funct3 = 3'b100; req_addr = 9'h013;
    @(negedge clk);
    n_run++; if (req_ready !== 1'b0 || mem_addr !== 9'h010 || mem_be !== 4'b1111) begin n_fail++; $display("FAIL hold_acc0 got rdy=%b addr=%h be=%b want 0/010/1111", req_ready, mem_addr, mem_be); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'hF0ADBEEF) begin n_fail++; $display("FAIL hold_resp got %b/%b/%h want 1/0/f0adbeef", resp_valid, req_ready, resp_rdata); end
    @(negedge clk);
    n_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'hF0ADBEEF) begin n_fail++; $display("FAIL hold_idle got %b/%b/%h want 1/0/f0adbeef", req_ready, resp_valid, resp_rdata); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_run++; if (mem_re !== 1'b1 || mem_be !== 4'b1000 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL hold_second got re=%b be=%b rd=%h want 1/1000/0", mem_re, mem_be, resp_rdata); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000F0) begin n_fail++; $display("FAIL hold_second_resp got %b/%h want 1/000000f0", resp_valid, resp_rdata); end
  endtask

  task automatic test_cross;
    send(1'b1, 3'b010, 9'h022, 32'h11223344);
    @(negedge clk);
    n_run++; if (mem_addr !== 9'h020 || mem_be !== 4'b1100 || mem_wdata !== 32'h33440000 || mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_x_acc0 got %h/%b/%h/%b want 020/1100/33440000/1", mem_addr, mem_be, mem_wdata, mem_we); end
    @(negedge clk);
    n_run++; if (mem_addr !== 9'h024 || mem_be !== 4'b0011 || mem_wdata !== 32'h00001122 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_x_acc1 got %h/%b/%h/%b want 024/0011/00001122/0", mem_addr, mem_be, mem_wdata, resp_valid); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL sw_x_resp got %b want 1", resp_valid); end
    send(1'b0, 3'b010, 9'h022, 32'h0);
    @(negedge clk); @(negedge clk);
    n_run++; if (resp_valid !== 1'b0 || mem_addr !== 9'h024 || mem_re !== 1'b1) begin n_fail++; $display("FAIL lw_x_acc1 got rv=%b addr=%h re=%b want 0/024/1", resp_valid, mem_addr, mem_re); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344) begin n_fail++; $display("FAIL lw_x_resp got %b/%h want 1/11223344", resp_valid, resp_rdata); end
  endtask

  task automatic test_wrap;
    send(1'b1, 3'b010, 9'h1FC, 32'h80123456);
    @(negedge clk); @(negedge clk);
    send(1'b1, 3'b010, 9'h000, 32'hABCDEF01);
    @(negedge clk); @(negedge clk);
    send(1'b0, 3'b001, 9'h1FF, 32'h0);
    @(negedge clk);
    n_run++; if (mem_addr !== 9'h1FC || mem_be !== 4'b1000) begin n_fail++; $display("FAIL lh_wrap_acc0 got %h/%b want 1fc/1000", mem_addr, mem_be); end
    @(negedge clk);
    n_run++; if (mem_addr !== 9'h000 || mem_be !== 4'b0001 || mem_re !== 1'b1) begin n_fail++; $display("FAIL lh_wrap_acc1 got %h/%b/%b want 000/0001/1", mem_addr, mem_be, mem_re); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000180) begin n_fail++; $display("FAIL lh_wrap_pos got %b/%h want 1/00000180", resp_valid, resp_rdata); end
    send(1'b1, 3'b000, 9'h000, 32'h00000081);
    @(negedge clk); @(negedge clk);
    send(1'b0, 3'b001, 9'h1FF, 32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF8180) begin n_fail++; $display("FAIL lh_wrap_neg got %b/%h want 1/ffff8180", resp_valid, resp_rdata); end
  endtask

  task automatic test_error;
    send(1'b0, 3'b011, 9'h010, 32'h0);
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b/%b/%h re=%b want 1/1/0/0", resp_valid, resp_err, resp_rdata, mem_re); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b0 || resp_err !== 1'b1) begin n_fail++; $display("FAIL ld_err_hold got %b/%b want 0/1", resp_valid, resp_err); end
    send(1'b1, 3'b100, 9'h010, 32'h12345678);
    n_run++; if (mem_we !== 1'b0 || mem_be !== 4'b0000) begin n_fail++; $display("FAIL st_err_nomem got we=%b be=%b want 0/0000", mem_we, mem_be); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin n_fail++; $display("FAIL st_err got %b/%b want 1/1", resp_valid, resp_err); end
    send(1'b0, 3'b010, 9'h010, 32'h0);
    @(negedge clk);
    n_run++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", resp_err); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hF0ADBEEF) begin n_fail++; $display("FAIL st_err_untouched got %b/%h want 1/f0adbeef", resp_valid, resp_rdata); end
  endtask

  task automatic test_reset_mid;
    send(1'b1, 3'b010, 9'h030, 32'h0);
    @(negedge clk); @(negedge clk);
    send(1'b1, 3'b010, 9'h034, 32'h0);
    @(negedge clk); @(negedge clk);
    send(1'b1, 3'b010, 9'h032, 32'hAABBCCDD);
    @(negedge clk);
    @(posedge clk);
    #2;
    n_run++; if (mem_addr !== 9'h034 || mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_acc1 got %h/%b want 034/1", mem_addr, mem_we); end
    reset = 1'b1;
    #1;
    n_run++; if ({mem_re, mem_we, mem_be} !== 6'b0 || {mem_addr, mem_wdata} !== 41'b0) begin n_fail++; $display("FAIL rstmid_mem got ctl=%b addr=%h data=%h want 0/0/0", {mem_re, mem_we, mem_be}, mem_addr, mem_wdata); end
    n_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl got rdy=%b rv=%b want 1/0", req_ready, resp_valid); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    n_run++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_nopulse0 got %b want 0", resp_valid); end
    @(negedge clk);
    n_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_nopulse1 got %b/%b want 0/1", resp_valid, req_ready); end
    send(1'b0, 3'b010, 9'h030, 32'h0);
    @(negedge clk); @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCCDD0000) begin n_fail++; $display("FAIL rstmid_first_word got %b/%h want 1/ccdd0000", resp_valid, resp_rdata); end
    send(1'b0, 3'b010, 9'h034, 32'h0);
    @(negedge clk); @(negedge clk);
    n_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000000) begin n_fail++; $display("FAIL rstmid_second_word got %b/%h want 1/00000000", resp_valid, resp_rdata); end
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 9'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_word;
    test_byte;
    test_hold;
    test_cross;
    test_wrap;
    test_error;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
